// File: rtl/instr_sequencer_pkg.sv
// Shared opcode and state definitions for the instruction sequencer, its ALU and its control decode.
package instr_sequencer_pkg;

   localparam int INSTR_W = 16;
   localparam int REG_CNT = 8;

   typedef enum logic [2:0] {
      OP_MV  = 3'b000,
      OP_MVI = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_SLT = 3'b110,
      OP_NOP = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T1   = 2'd1,
      T2   = 2'd2,
      T3   = 2'd3
   } state_t;

   // ALU instructions take the three-step path, everything else finishes in T1.
   function automatic logic is_alu_op(input opcode_t op);
      return (op != OP_MV) && (op != OP_MVI) && (op != OP_NOP);
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction input handshake and datapath control bus of the sequencer.
interface instr_sequencer_if;
   import instr_sequencer_pkg::*;

   logic [INSTR_W-1:0] iin;
   logic               run;
   logic               busy;
   logic               done;
   logic [2:0]         OpSelect;
   logic [2:0]         regNumSelect;
   logic               Rselect;
   logic               Iselect;
   logic               Aenable;
   logic               Renable;
   logic [REG_CNT-1:0] rEnable;

   modport master (
      output iin, run,
      input  busy, done, OpSelect, regNumSelect, Rselect, Iselect, Aenable, Renable, rEnable
   );

   modport slave (
      input  iin, run,
      output busy, done, OpSelect, regNumSelect, Rselect, Iselect, Aenable, Renable, rEnable
   );
endinterface

// File: rtl/instr_sequencer_reg_decoder.sv
// 3-to-8 one-hot register write-enable decoder, gated by a write strobe.
module reg_decoder
   import instr_sequencer_pkg::*;
(
   input  logic [2:0]         reg_num,
   input  logic               strobe,
   output logic [REG_CNT-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (strobe)
         onehot[reg_num] = 1'b1;
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: latches an instruction on run and steps the datapath controls through T1..T3.
module instr_sequencer
   import instr_sequencer_pkg::*;
(
   input  logic                clock,
   input  logic                Resetn,
   instr_sequencer_if.slave    bus
);

   state_t             state;
   logic [INSTR_W-1:0] ir;
   opcode_t            op;
   logic [2:0]         rx;
   logic [2:0]         ry;
   logic               write_strobe;

   assign op = opcode_t'(ir[15:13]);
   assign rx = ir[12:10];
   assign ry = ir[9:7];

   always_ff @(posedge clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= IDLE;
         ir    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.run) begin
                  ir    <= bus.iin;
                  state <= T1;
               end
            end
            T1:      state <= is_alu_op(op) ? T2 : IDLE;
            T2:      state <= T3;
            default: state <= IDLE;
         endcase
      end
   end

   // Controls depend only on state and IR, so reset clears them the moment state returns to IDLE.
   always_comb begin
      bus.busy         = (state != IDLE);
      bus.done         = 1'b0;
      bus.OpSelect     = 3'b000;
      bus.regNumSelect = 3'b000;
      bus.Rselect      = 1'b0;
      bus.Iselect      = 1'b0;
      bus.Aenable      = 1'b0;
      bus.Renable      = 1'b0;
      write_strobe     = 1'b0;
      case (state)
         T1: begin
            bus.OpSelect = op;
            case (op)
               OP_MV: begin
                  bus.regNumSelect = ry;
                  write_strobe     = 1'b1;
                  bus.done         = 1'b1;
               end
               OP_MVI: begin
                  bus.Iselect  = 1'b1;
                  write_strobe = 1'b1;
                  bus.done     = 1'b1;
               end
               OP_NOP: bus.done = 1'b1;
               default: begin
                  bus.regNumSelect = rx;
                  bus.Aenable      = 1'b1;
               end
            endcase
         end
         T2: begin
            bus.OpSelect     = op;
            bus.regNumSelect = ry;
            bus.Renable      = 1'b1;
         end
         T3: begin
            bus.OpSelect = op;
            bus.Rselect  = 1'b1;
            write_strobe = 1'b1;
            bus.done     = 1'b1;
         end
         default: ;
      endcase
   end

   reg_decoder u_reg_decoder (
      .reg_num (rx),
      .strobe  (write_strobe),
      .onehot  (bus.rEnable)
   );

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: per-cycle control outputs compared against a step-list model derived from the instruction rules.
module tb_instr_sequencer;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic [2:0] op;
      logic [2:0] rns;
      logic       rsel;
      logic       isel;
      logic       aen;
      logic       ren;
      logic [7:0] wen;
   } exp_t;

   logic clock;
   logic Resetn;
   int   compared;
   int   mismatched;
   exp_t modelQ[$];

   localparam exp_t IDLE_EXP = '0;

   instr_sequencer_if ifc ();

   instr_sequencer dut (
      .clock  (clock),
      .Resetn (Resetn),
      .bus    (ifc.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic exp_t mk(input logic busy, input logic done, input logic [2:0] op,
                               input logic [2:0] rns, input logic rsel, input logic isel,
                               input logic aen, input logic ren, input logic [7:0] wen);
      exp_t e;
      e.busy = busy; e.done = done; e.op = op; e.rns = rns;
      e.rsel = rsel; e.isel = isel; e.aen = aen; e.ren = ren; e.wen = wen;
      return e;
   endfunction

   // Each instruction expands into the list of per-cycle control words it must produce while busy.
   task automatic buildModel(input logic [15:0] instr);
      logic [2:0] op;
      int         rx;
      int         ry;
      logic [7:0] wx;
      op = instr[15:13];
      rx = int'(instr[12:10]);
      ry = int'(instr[9:7]);
      wx = 8'(1 << rx);
      modelQ.delete();
      case (op)
         3'b000: modelQ.push_back(mk(1, 1, op, 3'(ry), 0, 0, 0, 0, wx));
         3'b001: modelQ.push_back(mk(1, 1, op, 3'd0, 0, 1, 0, 0, wx));
         3'b111: modelQ.push_back(mk(1, 1, op, 3'd0, 0, 0, 0, 0, 8'd0));
         default: begin
            modelQ.push_back(mk(1, 0, op, 3'(rx), 0, 0, 1, 0, 8'd0));
            modelQ.push_back(mk(1, 0, op, 3'(ry), 0, 0, 0, 1, 8'd0));
            modelQ.push_back(mk(1, 1, op, 3'd0, 1, 0, 0, 0, wx));
         end
      endcase
   endtask

   task automatic checkOutput(input string tag, input exp_t e);
      exp_t obs;
      obs = mk(ifc.busy, ifc.done, ifc.OpSelect, ifc.regNumSelect, ifc.Rselect,
               ifc.Iselect, ifc.Aenable, ifc.Renable, ifc.rEnable);
      compared++;
      assert (obs === e) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   // Starts one instruction from IDLE, checks every busy cycle and the IDLE cycle that follows.
   task automatic applyStimulus(input logic [15:0] instr, input bit noise, input bit keep_run);
      buildModel(instr);
      ifc.iin = instr;
      ifc.run = 1'b1;
      foreach (modelQ[i]) begin
         @(negedge clock);
         checkOutput($sformatf("step%0d_%04h", i, instr), modelQ[i]);
         if (noise) begin
            ifc.run = 1'b1;
            ifc.iin = 16'($urandom);
         end else begin
            ifc.run = 1'b0;
         end
      end
      ifc.run = keep_run;
      @(negedge clock);
      checkOutput($sformatf("idle_after_%04h", instr), IDLE_EXP);
   endtask

   initial begin
      logic [15:0] instr;
      compared   = 0;
      mismatched = 0;
      ifc.iin    = 16'h0000;
      ifc.run    = 1'b0;
      Resetn     = 1'b0;
      #1;
      checkOutput("reset_async", IDLE_EXP);
      repeat (2) @(negedge clock);
      checkOutput("reset_held", IDLE_EXP);
      Resetn = 1'b1;
      @(negedge clock);
      checkOutput("idle_run0", IDLE_EXP);

      $display("[TB] directed: mvi, mv, add");
      applyStimulus(16'h2805, 1'b0, 1'b0);
      applyStimulus(16'h0500, 1'b0, 1'b0);
      applyStimulus(16'h4080, 1'b0, 1'b0);
      applyStimulus(16'h4D80, 1'b0, 1'b0);

      $display("[TB] directed: sub with run/iin noise while busy");
      applyStimulus(16'h6A00, 1'b1, 1'b0);

      $display("[TB] directed: reset during T2 of and");
      instr = 16'h9D00;
      buildModel(instr);
      ifc.iin = instr;
      ifc.run = 1'b1;
      @(negedge clock);
      checkOutput("and_T1", modelQ[0]);
      ifc.run = 1'b0;
      @(negedge clock);
      checkOutput("and_T2", modelQ[1]);
      #2 Resetn = 1'b0;
      #1;
      checkOutput("reset_mid_T2", IDLE_EXP);
      @(negedge clock);
      checkOutput("reset_no_write", IDLE_EXP);
      Resetn = 1'b1;
      applyStimulus(16'h3C7F, 1'b0, 1'b0);

      $display("[TB] directed: back-to-back with run held");
      applyStimulus(16'h2C01, 1'b0, 1'b1);
      applyStimulus(16'hE000, 1'b0, 1'b1);
      applyStimulus(16'hA100, 1'b0, 1'b0);

      $display("[TB] random instruction stream");
      for (int n = 0; n < 60; n++) begin
         applyStimulus(16'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            ifc.run = 1'b0;
            ifc.iin = 16'($urandom);
            @(negedge clock);
            checkOutput("idle_gap", IDLE_EXP);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The module SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 The module SHALL have port Resetn, input, 1 bit: asynchronous reset, active-low.
REQ-003 The module SHALL have port iin, input, 16 bits: instruction word; opcode iin[15:13], Rx iin[12:10], Ry iin[9:7], iin[6:0] immediate field (sign-extended by the datapath, not here).
REQ-004 The module SHALL have port run, input, 1 bit: start request, sampled only in IDLE.
REQ-005 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-006 The module SHALL have port done, output, 1 bit: one-cycle pulse in the final step of each instruction.
REQ-007 The module SHALL have port OpSelect, output, 3 bits: ALU operation code, equal to latched opcode.
REQ-008 The module SHALL have port regNumSelect, output, 3 bits: register driven onto bus.
REQ-009 The module SHALL have ports Rselect and Iselect, output, 1 bit each: bus source is ALU result / sign-extended immediate; never both high.
REQ-010 The module SHALL have ports Aenable and Renable, output, 1 bit each: load ALU operand A / ALU result register.
REQ-011 The module SHALL have port rEnable, output, 8 bits: one-hot write enable for R0..R7, at most one bit high.

Function
REQ-012 Opcodes SHALL be: 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 or, 110 slt, 111 nop.
REQ-013 The FSM SHALL have states IDLE, T1, T2, T3.
REQ-014 In IDLE with run=1 at a rising edge, iin SHALL be latched into the instruction register (IR) and the FSM SHALL move to T1; run=0 holds IDLE.
REQ-015 run and iin SHALL be ignored while busy=1; IR is stable from T1 to completion.
REQ-016 mv: T1 SHALL drive regNumSelect=Ry, rEnable[Rx]=1, done=1, then return to IDLE (2 cycles including IDLE).
REQ-017 mvi: T1 SHALL drive Iselect=1, rEnable[Rx]=1, done=1, then return to IDLE.
REQ-018 nop: T1 SHALL assert done=1 only, then return to IDLE.
REQ-019 ALU ops (010-110): T1 regNumSelect=Rx, Aenable=1; T2 regNumSelect=Ry, Renable=1; T3 Rselect=1, rEnable[Rx]=1, done=1; then IDLE.
REQ-020 OpSelect SHALL equal IR opcode in T1-T3 and 000 in IDLE.
REQ-021 All control outputs SHALL be decoded combinationally from state and IR only (no combinational path from iin or run).
REQ-022 Inactive outputs SHALL be 0; regNumSelect SHALL be 000 when not driving a register.
REQ-023 Rx=Ry SHALL be legal and follow the same sequence (e.g. add R3,R3 doubles R3).
REQ-024 run held high continuously SHALL start the next instruction on the cycle after done (IDLE cycle samples it).

Reset
REQ-025 Resetn=0 SHALL immediately force state IDLE, IR=0, and all outputs 0, including mid-instruction; no partial register write occurs after reset assertion.
REQ-026 After Resetn deasserts, the first rising edge SHALL treat the FSM as IDLE and sample run.

Structure
REQ-027 Opcode constants and state encodings SHALL live in a shared package (header) used also by the ALU and control decode.
REQ-028 A 3-to-8 one-hot decoder sub-module (reg_decoder) SHALL generate rEnable from Rx and a write strobe.

Verification
REQ-029 Reset then run=1, iin=mvi R2 #5 (0x2805) -> T1: Iselect=1, rEnable=0000_0100, done=1; busy high 1 cycle.
REQ-030 mv R1,R2 (0x0500) -> T1: regNumSelect=2, rEnable=0000_0010, done=1.
REQ-031 add R0,R1 (0x4080) -> T1 Aenable, regNumSelect=0; T2 Renable, regNumSelect=1, OpSelect=010; T3 Rselect, rEnable=0000_0001, done.
REQ-032 Change iin and pulse run during T2 of sub -> IR unchanged, sequence completes, new run ignored.
REQ-033 Resetn=0 during T2 of and -> all outputs 0 immediately, IDLE, no rEnable pulse afterwards.
REQ-034 run held high over two back-to-back instructions -> second starts on the cycle after first done; nop gives done in T1 with all other outputs 0.
